// File: rtl/decoupler.sv
// decoupler
// Splits 2*P_WIDTH-bit words popped from a show-ahead FIFO into single
// P_WIDTH-bit records. Each word holds {high record, low record}, and the low
// record is emitted first. An all-zero record ends a stream. When the low
// record is zero, the high record is padding and is dropped without being
// examined.
//
// Optional feature macro: STREAM_CNT_EN. When it is defined, o_stream_cnt
// counts the terminators that have been emitted. When it is undefined,
// o_stream_cnt is tied to zero and no counter flops exist.
//
// Ports:
//   i_clk        clock; all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_data       FIFO head word {high, low}; valid when i_empty=0
//   i_empty      upstream FIFO empty
//   o_deq        pop the upstream FIFO this cycle (combinational)
//   o_data       output record (registered)
//   o_valid      o_data holds a record (registered)
//   i_ready      consumer accepts o_data this cycle
//   o_rec_cnt    count of non-zero records emitted
//   o_stream_cnt count of terminators emitted (STREAM_CNT_EN only)
module decoupler #(
  parameter int unsigned P_WIDTH = 128,
  parameter int unsigned P_CNT_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [2*P_WIDTH-1:0] i_data,
  input  logic                 i_empty,
  output logic                 o_deq,
  output logic [P_WIDTH-1:0]   o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [P_CNT_W-1:0]   o_rec_cnt,
  output logic [P_CNT_W-1:0]   o_stream_cnt
);

  typedef enum logic {S_LOW, S_HIGH} state_t;

  state_t             state;
  logic               load;
  logic               fire;
  logic [P_WIDTH-1:0] sel;
  logic [P_WIDTH-1:0] low_half;
  logic [P_WIDTH-1:0] high_half;

  assign low_half  = i_data[P_WIDTH-1:0];
  assign high_half = i_data[2*P_WIDTH-1:P_WIDTH];

  // The output register can load when it is empty or is being drained.
  // In S_HIGH the head word is still in the FIFO, so i_empty is ignored.
  always_comb begin
    load  = ~o_valid | i_ready;
    fire  = 1'b0;
    sel   = low_half;
    o_deq = 1'b0;
    if (!i_rst) begin
      case (state)
        S_LOW: begin
          fire  = load & ~i_empty;
          o_deq = fire & (low_half == '0);
        end
        S_HIGH: begin
          fire  = load;
          sel   = high_half;
          o_deq = fire;
        end
        default: begin
          fire  = 1'b0;
          o_deq = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_LOW;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_rec_cnt <= '0;
    end else begin
      if (load) begin
        o_valid <= fire;
        if (fire) o_data <= sel;
      end
      if (fire) begin
        case (state)
          S_LOW:   state <= (low_half == '0) ? S_LOW : S_HIGH;
          S_HIGH:  state <= S_LOW;
          default: state <= S_LOW;
        endcase
        if (sel != '0) o_rec_cnt <= o_rec_cnt + P_CNT_W'(1);
      end
    end
  end

`ifdef STREAM_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_stream_cnt <= '0;
    else if (fire && sel == '0)
      o_stream_cnt <= o_stream_cnt + P_CNT_W'(1);
  end
`else
  assign o_stream_cnt = '0;
`endif

endmodule

// File: tb/tb_decoupler.sv
// Scoreboard bench for decoupler. The stimulus process models the show-ahead
// FIFO and pushes the expected records into a queue. A separate monitor
// process pops that queue and compares it on every accepted output record.
module tb_decoupler;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;
`ifdef STREAM_CNT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif
  localparam logic [W-1:0] A = 16'h1111, B = 16'h2222, C = 16'h3333, D = 16'h4444;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2*W-1:0]  i_data = '0;
  logic            i_empty = 1'b1;
  logic            o_deq;
  logic [W-1:0]    o_data;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [CW-1:0]   o_rec_cnt;
  logic [CW-1:0]   o_stream_cnt;

  logic [2*W-1:0]  fifo[$];
  logic [W-1:0]    exp_q[$];
  logic            deq_s = 1'b0;
  int              pops = 0;
  int              total = 0;
  int              passed = 0;

  decoupler #(.P_WIDTH(W), .P_CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_empty(i_empty),
    .o_deq(o_deq), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_rec_cnt(o_rec_cnt), .o_stream_cnt(o_stream_cnt)
  );

  always #5 clk = ~clk;

  // o_deq is sampled at the negedge, away from the edge that consumes it.
  always @(negedge clk) deq_s = o_deq;

  // Monitor: compares every accepted record against the scoreboard.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_record: got %h, none required", o_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) $display("FAIL record: got %h, required %h", o_data, e);
        else passed++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else passed++;
  endtask

  task automatic update_head();
    i_empty = (fifo.size() == 0);
    i_data  = i_empty ? '0 : fifo[0];
  endtask

  task automatic push(input logic [2*W-1:0] w);
    fifo.push_back(w);
    update_head();
  endtask

  // Advances one clock: the FIFO pop is applied just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (deq_s) begin
      if (fifo.size() != 0) void'(fifo.pop_front());
      pops++;
    end
    update_head();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_ready = 1'b0;
    fifo.delete();
    exp_q.delete();
    update_head();
    tick();
    tick();
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_deq", o_deq, 0);
    chk("rst_rec_cnt", o_rec_cnt, 0);
    chk("rst_stream_cnt", o_stream_cnt, 0);
    rst = 1'b0;
    pops = 0;
    tick();
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!o_valid && n < max) begin tick(); n++; end
    if (!o_valid) begin
      total++;
      $display("FAIL %s_timeout: o_valid 0 after %0d cycles, required 1", name, max);
    end
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin tick(); n++; end
    total++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: %0d records outstanding, required 0", name, exp_q.size());
    else passed++;
    repeat (4) tick();
  endtask

  initial begin
    // Scenario 1: two full words and a terminator-only word, gapless.
    do_reset();
    push({B, A}); push({D, C}); push(32'h0);
    exp_q.push_back(A); exp_q.push_back(B); exp_q.push_back(C);
    exp_q.push_back(D); exp_q.push_back(0);
    i_ready = 1'b1;
    wait_valid("s1", 10);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s1_gapless", o_valid, 1);
    end
    wait_drain("s1", 20);
    chk("s1_pops", pops, 3);
    chk("s1_rec_cnt", o_rec_cnt, 4);
    chk("s1_stream_cnt", o_stream_cnt, SC ? 1 : 0);

    // Scenario 2: odd-length stream, terminator in the high half.
    do_reset();
    push({B, A}); push({16'h0, C});
    exp_q.push_back(A); exp_q.push_back(B); exp_q.push_back(C); exp_q.push_back(0);
    i_ready = 1'b1;
    wait_drain("s2", 20);
    chk("s2_pops", pops, 2);
    chk("s2_rec_cnt", o_rec_cnt, 3);
    chk("s2_stream_cnt", o_stream_cnt, SC ? 1 : 0);

    // Scenario 3: the padding that shares a word with the terminator is dropped.
    do_reset();
    push({16'h00FF, 16'h0});
    exp_q.push_back(0);
    i_ready = 1'b1;
    wait_drain("s3", 20);
    chk("s3_pops", pops, 1);
    chk("s3_rec_cnt", o_rec_cnt, 0);
    chk("s3_stream_cnt", o_stream_cnt, SC ? 1 : 0);

    // Scenario 4: backpressure holds A stable with no pop.
    do_reset();
    push({B, A}); push({D, C});
    exp_q.push_back(A); exp_q.push_back(B); exp_q.push_back(C); exp_q.push_back(D);
    wait_valid("s4", 10);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("s4_hold_valid", o_valid, 1);
      chk("s4_hold_data", o_data, A);
      chk("s4_hold_deq", o_deq, 0);
    end
    chk("s4_hold_cnt", o_rec_cnt, 1);
    i_ready = 1'b1;
    wait_drain("s4", 20);
    chk("s4_pops", pops, 2);
    chk("s4_rec_cnt", o_rec_cnt, 4);
    chk("s4_stream_cnt", o_stream_cnt, 0);

    // Scenario 5: reset while in HIGH with A pending; the word is re-read.
    do_reset();
    push({B, A}); push(32'h0);
    wait_valid("s5", 10);
    chk("s5_pre_data", o_data, A);
    rst = 1'b1;
    tick();
    #1;
    chk("s5_rst_valid", o_valid, 0);
    chk("s5_rst_rec_cnt", o_rec_cnt, 0);
    chk("s5_rst_stream_cnt", o_stream_cnt, 0);
    chk("s5_fifo_kept", fifo.size(), 2);
    rst = 1'b0;
    pops = 0;
    exp_q.push_back(A); exp_q.push_back(B); exp_q.push_back(0);
    i_ready = 1'b1;
    wait_drain("s5", 20);
    chk("s5_pops", pops, 2);
    chk("s5_rec_cnt", o_rec_cnt, 2);
    chk("s5_stream_cnt", o_stream_cnt, SC ? 1 : 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
